// File: rtl/fetch_ifid_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
// Latency/backpressure: none (declarations only).
package fetch_ifid_pkg;

    localparam logic [3:0] OP_JMP_HALT = 4'b0000;
    localparam logic [3:0] OP_BGE      = 4'b0100;
    localparam logic [3:0] OP_BLE      = 4'b0101;
    localparam logic [3:0] OP_BEQ      = 4'b0110;
    localparam logic [3:0] OP_ANDI     = 4'b1000;
    localparam logic [3:0] OP_SW       = 4'b1011;
    localparam logic [3:0] OP_BR       = 4'b1100;
    localparam logic [3:0] OP_EXC      = 4'b1111;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int FUNC_HI = 3;
    localparam int FUNC_LO = 0;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ifid_t;

    // Instruction addresses are halfword aligned; bit 0 is never stored.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// Instruction-memory fetch bus: request/address out, word/ready back.
// Latency: memory answers with imem_ready in any later or same cycle; fetch re-requests until accepted.
interface fetch_ifid_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_ifid_ifid_reg.sv
// IF/ID pipeline register with load/flush/hold; 1-cycle latency.
// Backpressure: holds contents and valid whenever neither load nor flush is asserted.
module ifid_reg
    import fetch_ifid_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q,
    output logic  valid
);

    // Flush only drops valid; the stale word stays visible but is never acted on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage + IF/ID: returned word reaches opCode/funcCode one cycle after imem_ready.
// Backpressure: stall holds PC and IF/ID and discards the returned word, re-requesting the same pc.
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h00F0,
    parameter logic [3:0]  HALT_FUNC  = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_ifid_if.master imem,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        set_exc,
    output logic [3:0]  opCode,
    output logic [3:0]  funcCode,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic [15:0] epc,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic         req_q;
    ifid_t        ifid_q;
    ifid_t        ifid_d;

    logic in_fetch;
    logic halt_hit;
    logic take_exc;
    logic take_redir;
    logic take_halt;
    logic take_hold;
    logic take_load;
    logic ifid_flush;

    assign id_instr = ifid_q.instr;
    assign id_pc    = ifid_q.pc;
    assign opCode   = ifid_q.instr[OPC_HI:OPC_LO];
    assign funcCode = ifid_q.instr[FUNC_HI:FUNC_LO];

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // Priority chain: exception > redirect > halt > stall > accept > miss.
    assign in_fetch   = (state == FETCH);
    assign halt_hit   = id_valid && (opCode == OP_JMP_HALT) && (funcCode == HALT_FUNC) && !stall;
    assign take_exc   = in_fetch && set_exc && id_valid;
    assign take_redir = in_fetch && !take_exc && redirect_valid;
    assign take_halt  = in_fetch && !take_exc && !redirect_valid && halt_hit;
    assign take_hold  = in_fetch && !take_exc && !redirect_valid && !halt_hit && stall;
    assign take_load  = in_fetch && !take_exc && !redirect_valid && !halt_hit && !stall
                        && imem.imem_ready;
    assign ifid_flush = in_fetch && !take_load && !take_hold;

    assign ifid_d = '{instr: imem.imem_rdata, pc: pc};

    ifid_reg u_ifid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (take_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q),
        .valid (id_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            epc    <= 16'h0000;
            halted <= 1'b0;
            req_q  <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (take_exc) begin
                        pc  <= align_pc(EXC_VECTOR);
                        epc <= id_pc;
                    end else if (take_redir) begin
                        pc <= align_pc(redirect_pc);
                    end else if (take_halt) begin
                        state  <= HALTED;
                        req_q  <= 1'b0;
                        halted <= 1'b1;
                    end else if (take_load) begin
                        pc <= pc + 16'd2;
                    end
                end
                HALTED: begin
                    // Frozen until rst_n.
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule
